// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding and coin constants for the vend dispenser
package vend_pkg;
  typedef enum logic [2:0] {IDLE, VEND, CHG, EJECT, FAULT} state_t;
  localparam int CW = 3;
  localparam logic [CW-1:0] COIN_1 = 3'd1;
  localparam logic [CW-1:0] COIN_2 = 3'd2;
  localparam logic [CW-1:0] COIN_5 = 3'd5;
endpackage

// File: rtl/vend_fifo.sv
// vend_fifo: DEPTH-entry event queue, wrap-bit pointers, push+pop legal at any fill
module vend_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  // a simultaneous pop frees the slot the push needs
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= rd ? rp + 1'b1 : rp;
    end
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/vend_dispenser.sv
// vend_dispenser: queues vend events, runs motor then greedy 2/1 coin payout with timeout
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 1000,
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    delivery,
  input  logic [CW-1:0] change,
  output logic          vend_req,
  input  logic          vend_ack,
  output logic          eject_req,
  output logic          eject_sel,
  input  logic          eject_ack,
  output logic          busy,
  output logic          overflow,
  output logic          fault,
  input  logic          clr_fault
);
  state_t state, state_d;
  logic [CW-1:0] rem, rem_d, head;
  logic [TW-1:0] cnt, cnt_d;
  logic vend_req_d, eject_req_d, eject_sel_d, overflow_d;
  logic push, pop, full, empty, expired;
  assign push = |delivery;
  assign pop = (state == IDLE) && !empty;
  assign expired = cnt == TW'(TIMEOUT - 1);
  assign busy = (state != IDLE) || !empty;
  assign fault = state == FAULT;
  vend_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(change),
    .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rem <= '0;
      cnt <= '0;
      vend_req <= 1'b0;
      eject_req <= 1'b0;
      eject_sel <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      rem <= rem_d;
      cnt <= cnt_d;
      vend_req <= vend_req_d;
      eject_req <= eject_req_d;
      eject_sel <= eject_sel_d;
      overflow <= overflow_d;
    end
  always_comb begin
    state_d = state;
    rem_d = rem;
    cnt_d = cnt;
    vend_req_d = vend_req;
    eject_req_d = eject_req;
    eject_sel_d = eject_sel;
    overflow_d = (push && full && !pop) ? 1'b1 : clr_fault ? 1'b0 : overflow;
    case (state)
      IDLE:
        if (!empty) begin
          state_d = VEND;
          rem_d = head;
          cnt_d = '0;
        end
      // first VEND cycle raises the request; acks count only once it is up
      VEND:
        if (!vend_req) vend_req_d = 1'b1;
        else if (vend_ack) begin
          vend_req_d = 1'b0;
          state_d = (rem == '0) ? IDLE : CHG;
        end else if (expired) begin
          vend_req_d = 1'b0;
          state_d = FAULT;
        end else cnt_d = cnt + 1'b1;
      CHG: begin
        eject_sel_d = rem >= COIN_2;
        rem_d = (rem >= COIN_2) ? rem - COIN_2 : rem - COIN_1;
        eject_req_d = 1'b1;
        cnt_d = '0;
        state_d = EJECT;
      end
      EJECT:
        if (eject_ack) begin
          eject_req_d = 1'b0;
          eject_sel_d = 1'b0;
          state_d = (rem != '0) ? CHG : IDLE;
        end else if (expired) begin
          eject_req_d = 1'b0;
          eject_sel_d = 1'b0;
          state_d = FAULT;
        end else cnt_d = cnt + 1'b1;
      FAULT:
        if (clr_fault) begin
          state_d = IDLE;
          rem_d = '0;
        end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_vend_dispenser.sv
// tb_vend_dispenser: directed checks of vend/coin sequencing, overflow, timeout and reset
module tb_vend_dispenser;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 20;
  logic clk = 1'b0, rst = 1'b0;
  logic [2:0] delivery = '0, change = '0;
  logic vend_ack = 1'b0, eject_ack = 1'b0, clr_fault = 1'b0;
  logic vend_req, eject_req, eject_sel, busy, overflow, fault;
  int checks = 0, failures = 0;
  int nv = 0, nc = 0, vw = 0, last_vw = 0;
  logic coins [64];
  logic pv = 1'b0, pe = 1'b0;
  bit vhold = 0, ehold = 0;
  int vdly = 3, edly = 2, vc = 0, ec = 0;
  int bv, bc;

  vend_dispenser #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TW(5)) dut (
    .clk(clk), .rst(rst), .delivery(delivery), .change(change),
    .vend_req(vend_req), .vend_ack(vend_ack), .eject_req(eject_req),
    .eject_sel(eject_sel), .eject_ack(eject_ack), .busy(busy),
    .overflow(overflow), .fault(fault), .clr_fault(clr_fault)
  );

  always #5 clk = ~clk;

  // ack responders: pulse ack a fixed number of cycles after the req is seen
  initial forever begin
    @(posedge clk); #2;
    vend_ack = 1'b0;
    eject_ack = 1'b0;
    if (vend_req && !vhold) begin
      vc++;
      if (vc == vdly) begin vend_ack = 1'b1; vc = 0; end
    end else vc = 0;
    if (eject_req && !ehold) begin
      ec++;
      if (ec == edly) begin eject_ack = 1'b1; ec = 0; end
    end else ec = 0;
  end

  always @(negedge clk) begin
    if (vend_req && !pv) begin nv++; vw = 0; end
    if (vend_req) vw++;
    else if (pv) last_vw = vw;
    if (eject_req && !pe && nc < 64) begin coins[nc] = eject_sel; nc++; end
    pv = vend_req;
    pe = eject_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [2:0] d, input logic [2:0] ch);
    delivery = d;
    change = ch;
    step();
    delivery = '0;
    change = '0;
  endtask

  task automatic wait_idle(input string tag, input int n);
    int k;
    for (k = 0; k < n && busy; k++) step();
    chk(tag, busy, 0);
    step();
  endtask

  initial begin
    repeat (3) step();
    chk("rst_vend_req", vend_req, 0);
    chk("rst_eject_req", eject_req, 0);
    chk("rst_eject_sel", eject_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b1;
    step();

    // single event, no change, ack 3 cycles after req
    bv = nv; bc = nc;
    send(3'd1, 3'd0);
    chk("t1_req_edge_n", vend_req, 0);
    chk("t1_busy_queued", busy, 1);
    step();
    chk("t1_req_edge_n1", vend_req, 0);
    step();
    chk("t1_req_edge_n2", vend_req, 1);
    wait_idle("t1_idle", 100);
    chk("t1_req_width", last_vw, 3);
    chk("t1_vends", nv - bv, 1);
    chk("t1_coins", nc - bc, 0);
    chk("t1_overflow", overflow, 0);

    // change 3 pays {2,1}
    vdly = 2; edly = 2;
    bv = nv; bc = nc;
    send(3'd6, 3'd3);
    wait_idle("t2_idle", 100);
    chk("t2_vends", nv - bv, 1);
    chk("t2_coins", nc - bc, 2);
    chk("t2_coin0", coins[bc], 1);
    chk("t2_coin1", coins[bc+1], 0);

    // change 4 then change 1 on consecutive clocks
    bv = nv; bc = nc;
    send(3'd2, 3'd4);
    send(3'd7, 3'd1);
    wait_idle("t3_idle", 200);
    chk("t3_vends", nv - bv, 2);
    chk("t3_coins", nc - bc, 3);
    chk("t3_coin0", coins[bc], 1);
    chk("t3_coin1", coins[bc+1], 1);
    chk("t3_coin2", coins[bc+2], 0);
    chk("t3_overflow", overflow, 0);

    // DEPTH+2 back-to-back events while the motor stalls
    vdly = 3;
    vhold = 1;
    bv = nv; bc = nc;
    for (int i = 0; i < DEPTH + 2; i++) send(3'd1, 3'd0);
    chk("t4_overflow_set", overflow, 1);
    vhold = 0;
    wait_idle("t4_idle", 300);
    chk("t4_served", nv - bv, DEPTH + 1);
    chk("t4_overflow_sticky", overflow, 1);
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    chk("t4_overflow_clr", overflow, 0);
    chk("t4_no_fault", fault, 0);

    // motor timeout, then recovery serves the queued event
    vhold = 1;
    bv = nv; bc = nc;
    send(3'd1, 3'd0);
    send(3'd1, 3'd2);
    for (int k = 0; k < 60 && !fault; k++) step();
    chk("t5_fault", fault, 1);
    chk("t5_req_dropped", vend_req, 0);
    step();
    chk("t5_req_width", last_vw, TIMEOUT);
    repeat (3) step();
    chk("t5_fault_sticky", fault, 1);
    chk("t5_busy", busy, 1);
    vhold = 0;
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    chk("t5_fault_clr", fault, 0);
    wait_idle("t5_idle", 200);
    chk("t5_vends", nv - bv, 2);
    chk("t5_coins", nc - bc, 1);
    chk("t5_coin0", coins[bc], 1);

    // reset asserted in EJECT with rem=2 and one event queued
    ehold = 1;
    bv = nv; bc = nc;
    send(3'd1, 3'd4);
    send(3'd1, 3'd1);
    for (int k = 0; k < 60 && !eject_req; k++) step();
    chk("t6_in_eject", eject_req, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_eject_req", eject_req, 0);
    chk("t6_rst_eject_sel", eject_sel, 0);
    chk("t6_rst_vend_req", vend_req, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_fault", fault, 0);
    step();
    step();
    rst = 1'b1;
    ehold = 0;
    bc = nc; bv = nv;
    repeat (10) step();
    chk("t6_no_eject", nc - bc, 0);
    chk("t6_no_vend", nv - bv, 0);
    chk("t6_fifo_empty", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Downstream stage of the vending FSM. Consumes its registered `delivery`/`change` vend events and queues them in a small FIFO.
- Per event: drives the product motor through a req/ack handshake, then pays out change as a greedy sequence of 2-unit and 1-unit coins through the coin-ejector handshake.
- Provides timeout supervision, a sticky fault state, and queue-overflow reporting.

Parameters:
- DEPTH, 4, vend-event FIFO depth in entries (power of two, ≥2).
- TIMEOUT, 1000, max cycles a req may wait for its ack before FAULT.
- TW, 10, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- delivery  input  3  from vend FSM; nonzero for one cycle = one vend event.
- change  input  3  change owed with the event, units 0..7; sampled only when delivery≠0.
- vend_req  output  1  product motor request.
- vend_ack  input  1  motor done, single-cycle pulse.
- eject_req  output  1  coin ejector request.
- eject_sel  output  1  coin select while eject_req=1: 1 = 2-unit coin, 0 = 1-unit coin.
- eject_ack  input  1  ejector done, single-cycle pulse.
- busy  output  1  high when state≠IDLE or the FIFO is non-empty.
- overflow  output  1  sticky; event dropped because the FIFO was full.
- fault  output  1  high while in FAULT.
- clr_fault  input  1  synchronous; leaves FAULT and clears overflow.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, FIFO empty, timeout counter and remaining-change register cleared.
- Push:
  - Every rising edge with delivery≠0 pushes change[2:0].
  - Only the nonzero-ness of delivery matters; its value is not stored.
  - Push while full and no pop that edge: event dropped, overflow←1.
  - Push and pop on the same edge while full: both happen, no overflow.
- FSM states: IDLE, VEND, CHG, EJECT, FAULT.
- IDLE:
  - If the FIFO is non-empty: pop the head into rem[2:0], go to VEND, vend_req←1.
  - An event pushed at edge N sees vend_req=1 after edge N+2 when the FSM was idle.
- VEND:
  - vend_req held until vend_ack is sampled 1; then vend_req←0.
  - Next state is CHG, or IDLE if rem=0.
- CHG (one cycle, no outputs):
  - rem≥2 → eject_sel←1, rem←rem−2.
  - rem=1 → eject_sel←0, rem←0.
  - Either way: eject_req←1, go to EJECT.
- EJECT:
  - eject_req and eject_sel held stable until eject_ack is sampled 1; then eject_req←0.
  - Go to CHG if rem≠0, else IDLE.
- Coin sequences: 1→{1}, 2→{2}, 3→{2,1}, 4→{2,2}, 7→{2,2,2,1}.
- Handshake rules:
  - Req outputs are registered.
  - An ack arriving while the matching req=0 is ignored.
  - vend_ack is ignored in EJECT; eject_ack is ignored in VEND.
- Timeout:
  - The counter is cleared on entry to VEND/EJECT and increments each cycle while waiting.
  - Reaching TIMEOUT with no ack: all reqs←0, go to FAULT, fault=1.
- FAULT:
  - The current event is abandoned. The FIFO keeps accepting, and overflow still applies.
  - clr_fault=1 → IDLE next edge, fault←0, overflow←0; queued events are then served.
- clr_fault outside FAULT clears overflow only.
- Reset mid-operation: immediate return to reset values; queued events are lost.

Decomposition:
- Shared package vend_pkg: state enum, coin-unit constants (COIN_1=1, COIN_2=2, COIN_5=5), change width (3).
- One sub-module vend_fifo:
  - Parameterised DEPTH×3 synchronous FIFO with push/pop/full/empty.
  - Pointers carry a wrap bit.
  - Same-edge push+pop is legal at any fill level.

Test Plan:
- Event delivery=1, change=0; vend_ack 3 cycles after vend_req → vend_req high exactly until ack, no eject_req, busy returns 0, no overflow.
- Event change=3; acks after 2 cycles each → vend, then eject_sel=1, then eject_sel=0; exactly two eject_req pulses.
- Event change=4, then change=1 on the next clock → first event pays {2,2}, second pays {1}, in order; overflow=0.
- DEPTH+2 events on back-to-back cycles while vend_ack is held off → DEPTH+1 events served in total (one popped into the FSM plus DEPTH queued); overflow=1.
- No vend_ack for TIMEOUT cycles → vend_req drops, fault=1; then clr_fault → IDLE, and the next queued event vends.
- rst pulled low in EJECT with rem=2 → all outputs 0 immediately, FIFO empty; after release, no eject_req until a new event.
